// File: rtl/spi_reg_bridge.sv
// ============================================================================
// Module   : spi_reg_bridge
// Brief    : Decodes framed SPI command bytes into register-bus reads/writes
//            and supplies the next byte to shift out to the host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_bridge #(
    parameter int          ADDR_W    = 7,
    parameter bit          BURST_EN  = 1'b1,
    parameter logic [7:0]  IDLE_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ss,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [ADDR_W-1:0]  reg_addr_q, reg_addr_d;
    logic [7:0]         reg_wdata_q, reg_wdata_d;
    logic               reg_we_q, reg_we_d;
    logic               reg_re_q, reg_re_d;

    always_comb begin
        state_d     = state_q;
        tx_byte_d   = tx_byte_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;

        // Burst writes advance the address in the cycle after the strobe
        if (BURST_EN && reg_we_q) begin
            reg_addr_d = reg_addr_q + ADDR_W'(1);
        end

        if (ss) begin
            state_d   = ST_IDLE;
            tx_byte_d = IDLE_BYTE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        reg_addr_d = rx_byte[ADDR_W-1:0];
                        if (rx_byte[7]) begin
                            state_d = ST_WR_DATA;
                        end else begin
                            reg_re_d = 1'b1;
                            state_d  = ST_RD_REQ;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (rx_valid) begin
                        reg_wdata_d = rx_byte;
                        reg_we_d    = 1'b1;
                        if (!BURST_EN) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                // reg_re is on the bus here; read data appears next cycle
                ST_RD_REQ: state_d = ST_RD_WAIT;
                ST_RD_WAIT: begin
                    tx_byte_d = reg_rdata;
                    state_d   = ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (rx_valid) begin
                        if (BURST_EN) begin
                            reg_addr_d = reg_addr_q + ADDR_W'(1);
                            reg_re_d   = 1'b1;
                            state_d    = ST_RD_REQ;
                        end else begin
                            tx_byte_d = IDLE_BYTE;
                            state_d   = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tx_byte_q   <= IDLE_BYTE;
            reg_addr_q  <= '0;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_byte_q   <= tx_byte_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
        end
    end

    assign tx_byte   = tx_byte_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
// ============================================================================
// Module   : tb_spi_reg_bridge
// Brief    : Directed self-checking bench for spi_reg_bridge (burst and
//            single-access variants driven side by side).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_reg_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss;
    logic [7:0] rx_byte;
    logic       rx_valid;

    logic [7:0] tx1, wdata1, rdata1;
    logic [6:0] addr1;
    logic       we1, re1, busy1;
    logic [7:0] tx0, wdata0, rdata0;
    logic [6:0] addr0;
    logic       we0, re0, busy0;

    logic [7:0] mem [0:127];

    int n_checks = 0;
    int n_fail   = 0;

    int         we1_n = 0, re1_n = 0, we0_n = 0, overlap_n = 0;
    logic [6:0] we1_addr [0:63];
    logic [7:0] we1_data [0:63];
    logic [6:0] re1_addr [0:63];
    logic [6:0] we0_last_addr;
    logic [7:0] we0_last_data;

    always #5 clk = ~clk;

    spi_reg_bridge #(.ADDR_W(7), .BURST_EN(1'b1), .IDLE_BYTE(8'hA5)) dut (
        .clk(clk), .reset(rst), .ss(ss), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx1), .reg_addr(addr1), .reg_wdata(wdata1), .reg_we(we1),
        .reg_re(re1), .reg_rdata(rdata1), .busy(busy1)
    );

    spi_reg_bridge #(.ADDR_W(7), .BURST_EN(1'b0), .IDLE_BYTE(8'hA5)) dut0 (
        .clk(clk), .reset(rst), .ss(ss), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx0), .reg_addr(addr0), .reg_wdata(wdata0), .reg_we(we0),
        .reg_re(re0), .reg_rdata(rdata0), .busy(busy0)
    );

    // Register file model: read data one cycle after the strobe
    always @(posedge clk) begin
        if (re1) rdata1 <= mem[addr1];
        if (re0) rdata0 <= mem[addr0];
        if (we1) begin
            we1_addr[we1_n[5:0]] <= addr1;
            we1_data[we1_n[5:0]] <= wdata1;
            we1_n <= we1_n + 1;
        end
        if (re1) begin
            re1_addr[re1_n[5:0]] <= addr1;
            re1_n <= re1_n + 1;
        end
        if (we0) begin
            we0_last_addr <= addr0;
            we0_last_data <= wdata0;
            we0_n <= we0_n + 1;
        end
        if ((we1 && re1) || (we0 && re0)) overlap_n <= overlap_n + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the falling edge just after the byte was sampled
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    int we_base, re_base, we0_base;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[7'h05] = 8'h3C;
        mem[7'h10] = 8'h11;
        mem[7'h11] = 8'h22;
        mem[7'h20] = 8'h77;
        rst = 1'b1; ss = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_eq("rst_tx",    tx1,    8'hA5);
        check_eq("rst_addr",  addr1,  7'h00);
        check_eq("rst_wdata", wdata1, 8'h00);
        check_eq("rst_we",    we1,    1'b0);
        check_eq("rst_re",    re1,    1'b0);
        check_eq("rst_busy",  busy1,  1'b0);

        // Reset mid-frame while in WR_DATA
        ss = 1'b0;
        send_byte(8'h83);
        check_eq("wr_cmd_busy", busy1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_tx",   tx1,   8'hA5);
        check_eq("midrst_addr", addr1, 7'h00);
        check_eq("midrst_busy", busy1, 1'b0);
        check_eq("midrst_we",   we1,   1'b0);
        send_byte(8'h05);
        check_eq("midrst_rd_re",   re1,   1'b1);
        check_eq("midrst_rd_addr", addr1, 7'h05);
        idle(3);
        check_eq("midrst_rd_tx", tx1, 8'h3C);
        ss = 1'b1;
        idle(2);
        check_eq("ss_hi_tx", tx1, 8'hA5);

        // Simple write frame
        we_base = we1_n; re_base = re1_n;
        ss = 1'b0;
        send_byte(8'h83); idle(4);
        send_byte(8'h5C); idle(4);
        ss = 1'b1; idle(2);
        check_eq("wr_count", we1_n - we_base, 1);
        check_eq("wr_addr",  we1_addr[we_base[5:0]], 7'h03);
        check_eq("wr_data",  we1_data[we_base[5:0]], 8'h5C);
        check_eq("wr_no_re", re1_n - re_base, 0);

        // Burst read with prefetch
        re_base = re1_n;
        ss = 1'b0;
        send_byte(8'h10);
        @(negedge clk);
        check_eq("rd_tx_early", tx1, 8'hA5);
        @(negedge clk);
        check_eq("rd_tx_lat3", tx1, 8'h11);
        check_eq("rd0_tx_lat3", tx0, 8'h11);
        idle(3);
        send_byte(8'h00);
        idle(2);
        check_eq("rd_tx_2nd", tx1, 8'h22);
        check_eq("rd0_tx_done", tx0, 8'hA5);
        check_eq("rd0_busy_done", busy0, 1'b1);
        idle(3);
        send_byte(8'h00);
        idle(4);
        ss = 1'b1; idle(2);
        check_eq("rd_re_count", re1_n - re_base, 3);
        check_eq("rd_re_a0", re1_addr[re_base[5:0]],        7'h10);
        check_eq("rd_re_a1", re1_addr[6'(re_base + 1)],     7'h11);
        check_eq("rd_re_a2", re1_addr[6'(re_base + 2)],     7'h12);
        check_eq("rd_abort_tx", tx1, 8'hA5);

        // Burst write wrapping past the top address
        we_base = we1_n; we0_base = we0_n;
        ss = 1'b0;
        send_byte(8'hFF); idle(4);
        send_byte(8'hAA); idle(4);
        send_byte(8'hBB); idle(4);
        ss = 1'b1; idle(2);
        check_eq("wrap_count", we1_n - we_base, 2);
        check_eq("wrap_a0", we1_addr[we_base[5:0]],    7'h7F);
        check_eq("wrap_d0", we1_data[we_base[5:0]],    8'hAA);
        check_eq("wrap_a1", we1_addr[6'(we_base + 1)], 7'h00);
        check_eq("wrap_d1", we1_data[6'(we_base + 1)], 8'hBB);
        check_eq("wrap0_count", we0_n - we0_base, 1);

        // Single-access variant ignores bytes after the first data byte
        we0_base = we0_n;
        ss = 1'b0;
        send_byte(8'h82); idle(4);
        send_byte(8'h01); idle(4);
        send_byte(8'h02); idle(4);
        check_eq("nb_count", we0_n - we0_base, 1);
        check_eq("nb_addr",  we0_last_addr, 7'h02);
        check_eq("nb_data",  we0_last_data, 8'h01);
        check_eq("nb_busy",  busy0, 1'b1);
        ss = 1'b1; idle(1);
        check_eq("nb_busy_ss", busy0, 1'b0);

        // ss rises together with a write data byte
        we_base = we1_n; we0_base = we0_n;
        ss = 1'b0;
        send_byte(8'h83); idle(4);
        @(negedge clk);
        rx_byte = 8'h5C; rx_valid = 1'b1; ss = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check_eq("abw_we",   we1,   1'b0);
        check_eq("abw_busy", busy1, 1'b0);
        check_eq("abw_tx",   tx1,   8'hA5);
        idle(3);
        check_eq("abw_count",  we1_n - we_base,  0);
        check_eq("abw0_count", we0_n - we0_base, 0);

        // ss rises while waiting for read data
        ss = 1'b0;
        send_byte(8'h20);
        @(negedge clk);
        ss = 1'b1;
        @(negedge clk);
        check_eq("abr_tx",   tx1,   8'hA5);
        check_eq("abr_busy", busy1, 1'b0);
        idle(3);
        check_eq("abr_tx_late", tx1, 8'hA5);

        // Stray byte with no frame
        we_base = we1_n; re_base = re1_n;
        send_byte(8'h81); idle(3);
        send_byte(8'h11); idle(3);
        check_eq("stray_busy", busy1, 1'b0);
        check_eq("stray_we",   we1_n - we_base, 0);
        check_eq("stray_re",   re1_n - re_base, 0);

        check_eq("no_we_re_overlap", overlap_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Command/register bridge directly downstream of spi_slave in the SPI subsystem.
- Consumes received bytes (spi_slave q / finished) and decodes framed read/write commands into a simple register-bus.
- Drives the byte spi_slave shifts out next (spi_slave d), so host reads return register contents within the same ss frame.

Parameters:
- ADDR_W, 7, register address width; command byte bits [ADDR_W-1:0]; must be <= 7.
- BURST_EN, 1, 1 = auto-increment address for subsequent data bytes in a frame; 0 = one access per frame, extra bytes ignored.
- IDLE_BYTE, 8'hA5, value presented on tx_byte whenever no read data is pending.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- ss, input, 1, SPI slave select, active low, already synchronised to clk; high = no frame.
- rx_byte, input, 8, byte received by spi_slave (its q); valid only while rx_valid = 1.
- rx_valid, input, 1, single-cycle strobe, byte complete (spi_slave finished).
- tx_byte, output, 8, byte for spi_slave to shift out on the next transfer (its d).
- reg_addr, output, ADDR_W, register address.
- reg_wdata, output, 8, write data.
- reg_we, output, 1, single-cycle write strobe.
- reg_re, output, 1, single-cycle read strobe.
- reg_rdata, input, 8, read data; valid exactly one cycle after reg_re.
- busy, output, 1, high while state != IDLE.

Behaviour:
- Reset (sync, all state): state = IDLE, tx_byte = IDLE_BYTE, reg_addr = 0, reg_wdata = 0, reg_we = 0, reg_re = 0, busy = 0.
- Frame protocol:
  - First byte after ss falls is the command: bit7 = 1 write, 0 read; bits[ADDR_W-1:0] = start address; bits [6:ADDR_W] ignored.
- States:
  - IDLE:
    - rx_valid with ss = 0 latches reg_addr from the command byte.
    - Write command -> WR_DATA.
    - Read command -> pulse reg_re in the next cycle, go to RD_WAIT.
  - WR_DATA: on rx_valid, reg_wdata <= rx_byte and reg_we pulses for one cycle at the current reg_addr.
    - BURST_EN = 1: reg_addr increments in the cycle after reg_we; stay in WR_DATA.
    - BURST_EN = 0: go to DONE.
  - RD_WAIT: exactly one cycle; capture reg_rdata into tx_byte and go to RD_DATA.
    - Latency: from the command rx_valid to tx_byte updated is 3 clk cycles.
  - RD_DATA: tx_byte holds the read value until the next rx_valid (the host's dummy byte); the received byte content is ignored.
    - BURST_EN = 1: reg_addr++, pulse reg_re, go to RD_WAIT (prefetch next).
    - BURST_EN = 0: tx_byte <= IDLE_BYTE, go to DONE.
  - DONE: ignore all rx_valid until ss goes high.
- Address wrap: reg_addr increments modulo 2^ADDR_W (all-ones -> 0), no error.
- ss = 1 in any state, including during a reg_re/RD_WAIT:
  - next state IDLE and tx_byte <= IDLE_BYTE.
  - Any pending reg_re already issued completes but its data is discarded.
  - No reg_we is issued for the partial/aborted byte.
- ss = 1 and rx_valid in the same cycle: ss wins, byte dropped, no strobe.
- rx_valid while ss = 1 (stray) is ignored.
- reg_we and reg_re are never high in the same cycle; each is high for at most one cycle per accepted byte.
- Host timing requirement: at least 4 clk cycles between rx_valid strobes.
  - rx_valid arriving in RD_WAIT is not serviced in that cycle; behaviour is then undefined and need not be checked.

Test Plan:
- Reset mid-frame in WR_DATA with ss = 0 -> next cycle:
  - all outputs at reset values, tx_byte = 8'hA5, state IDLE;
  - subsequent byte 8'h05 is treated as a read command.
- Write frame, bytes 8'h83, 8'h5C -> one reg_we with reg_addr = 3, reg_wdata = 8'h5C; no reg_re.
- Read frame, BURST_EN = 1, regs[0x10] = 8'h11, regs[0x11] = 8'h22:
  - bytes 8'h10, dummy, dummy;
  - tx_byte = 8'h11 three cycles after the first rx_valid;
  - tx_byte = 8'h22 after the first dummy;
  - reg_re pulses at addresses 0x10, 0x11, 0x12.
- Burst write wrap, ADDR_W = 7, bytes 8'hFF, 8'hAA, 8'hBB -> reg_we at addr 0x7F (8'hAA), then addr 0x00 (8'hBB).
- BURST_EN = 0, bytes 8'h82, 8'h01, 8'h02 -> a single write (addr 2, 8'h01); third byte produces no strobe; busy stays 1 until ss rises.
- Abort tests:
  - ss rises in the same cycle as the data rx_valid of a write -> no reg_we, IDLE next cycle, tx_byte = 8'hA5.
  - ss rises during RD_WAIT -> tx_byte = 8'hA5, not the read data.
